// File: rtl/network_tx_arb_if.sv
// network_tx_arb_if: request-side handshake and outgoing link of network_tx_arb.
//   req_v       per-channel request valid            (requesters -> arbiter)
//   req_packet  per-channel packets, channel c at [c*packet_width_p +: packet_width_p]
//   req_invalid per-channel invalid-EVA flag         (requesters -> arbiter)
//   req_yumi    per-channel consumed (sent/dropped)  (arbiter -> requesters)
//   out_packet  registered outgoing packet           (arbiter -> network)
//   out_v       registered valid, valid-credit link  (arbiter -> network)
//   out_credit  one link credit returned per cycle   (network -> arbiter)
// slave = arbiter view, master = requester/network view.
interface network_tx_arb_if #(
  parameter int num_chan_p     = 4,
  parameter int packet_width_p = 128
);
  logic [num_chan_p-1:0]                req_v;
  logic [num_chan_p*packet_width_p-1:0] req_packet;
  logic [num_chan_p-1:0]                req_invalid;
  logic [num_chan_p-1:0]                req_yumi;
  logic [packet_width_p-1:0]            out_packet;
  logic                                 out_v;
  logic                                 out_credit;

  modport master (
    output req_v, req_packet, req_invalid, out_credit,
    input  req_yumi, out_packet, out_v
  );

  modport slave (
    input  req_v, req_packet, req_invalid, out_credit,
    output req_yumi, out_packet, out_v
  );
endinterface

// File: rtl/network_tx_arb.sv
// network_tx_arb: round-robin arbiter of num_chan_p request channels onto one
// valid-credit manycore request link, with per-channel outstanding tracking,
// invalid-EVA drop/flagging and a registered outgoing packet.
// Ports:
//   clk_i, reset_n_i       clock, asynchronous active-low reset
//   link (slave)           request handshake + outgoing link (network_tx_arb_if)
//   resp_v_i, resp_chan_i  one response retired for channel resp_chan_i
//   outstanding_zero_o     per-channel "no requests outstanding" (fence ok)
//   credits_avail_o        current link credit count
//   invalid_access_o       sticky per-channel invalid-EVA flag
//   stat_sent_o            per-channel 32-bit sent counters
// Optional: define NETWORK_TX_ARB_STATS_EN to build the sent counters;
// otherwise stat_sent_o is tied to zero.
module network_tx_arb #(
  parameter int num_chan_p        = 4,
  parameter int packet_width_p    = 128,
  parameter int max_out_credits_p = 32,
  parameter int max_outstanding_p = 63,
  localparam int chan_w = (num_chan_p > 1) ? $clog2(num_chan_p) : 1,
  localparam int cred_w = $clog2(max_out_credits_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  network_tx_arb_if.slave          link,
  input  logic                     resp_v_i,
  input  logic [chan_w-1:0]        resp_chan_i,
  output logic [num_chan_p-1:0]    outstanding_zero_o,
  output logic [cred_w-1:0]        credits_avail_o,
  output logic [num_chan_p-1:0]    invalid_access_o,
  output logic [num_chan_p*32-1:0] stat_sent_o
);
  localparam int out_w = $clog2(max_outstanding_p + 1);

  logic [cred_w-1:0]         credits_q, credits_d;
  logic [chan_w-1:0]         ptr_q, ptr_d;
  logic [out_w-1:0]          outst_q [num_chan_p];
  logic [out_w-1:0]          outst_d [num_chan_p];
  logic [num_chan_p-1:0]     invalid_q, invalid_d;
  logic                      out_v_q, out_v_d;
  logic [packet_width_p-1:0] out_packet_q, out_packet_d;

  logic [num_chan_p-1:0]     send_elig, drop_elig, grant_oh, dec_oh;
  logic [chan_w-1:0]         cand, grant_idx;
  logic                      grant_found, grant_v;
  logic                      resp_at_zero, credit_overflow;

  always_comb begin
    for (int unsigned c = 0; c < num_chan_p; c++) begin
      send_elig[c] = link.req_v[c] & ~link.req_invalid[c]
                   & (outst_q[c] != out_w'(max_outstanding_p));
      drop_elig[c] = link.req_v[c] & link.req_invalid[c];
    end
  end

  // Round-robin search starting at ptr_q; first eligible channel wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < num_chan_p; i++) begin
      cand = chan_w'((32'(ptr_q) + i) % num_chan_p);
      if (!grant_found && send_elig[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_v = grant_found && (credits_q != '0);
  end

  always_comb begin
    grant_oh = '0;
    if (grant_v) grant_oh[grant_idx] = 1'b1;
    // Drops are acknowledged regardless of arbitration or credits.
    link.req_yumi = drop_elig | grant_oh;
  end

  always_comb begin
    ptr_d        = ptr_q;
    out_v_d      = grant_v;
    out_packet_d = out_packet_q;
    if (grant_v) begin
      ptr_d        = (32'(grant_idx) == num_chan_p - 1) ? '0 : grant_idx + chan_w'(1);
      out_packet_d = link.req_packet[grant_idx*packet_width_p +: packet_width_p];
    end
    invalid_d = invalid_q | drop_elig;
  end

  // Credit return while full is illegal; the counter saturates instead of wrapping.
  always_comb begin
    credits_d       = credits_q;
    credit_overflow = link.out_credit && (credits_q == cred_w'(max_out_credits_p));
    if (grant_v && !link.out_credit) credits_d = credits_q - cred_w'(1);
    else if (!grant_v && link.out_credit && !credit_overflow) credits_d = credits_q + cred_w'(1);
  end

  always_comb begin
    resp_at_zero = 1'b0;
    for (int unsigned c = 0; c < num_chan_p; c++) begin
      dec_oh[c]  = resp_v_i && (32'(resp_chan_i) == c);
      outst_d[c] = outst_q[c];
      if (grant_oh[c] && !dec_oh[c]) outst_d[c] = outst_q[c] + out_w'(1);
      else if (dec_oh[c] && !grant_oh[c]) begin
        if (outst_q[c] == '0) resp_at_zero = 1'b1;
        else                  outst_d[c]   = outst_q[c] - out_w'(1);
      end
      outstanding_zero_o[c] = (outst_q[c] == '0);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credits_q    <= cred_w'(max_out_credits_p);
      ptr_q        <= '0;
      invalid_q    <= '0;
      out_v_q      <= 1'b0;
      out_packet_q <= '0;
      for (int unsigned c = 0; c < num_chan_p; c++) outst_q[c] <= '0;
    end else begin
      credits_q    <= credits_d;
      ptr_q        <= ptr_d;
      invalid_q    <= invalid_d;
      out_v_q      <= out_v_d;
      out_packet_q <= out_packet_d;
      for (int unsigned c = 0; c < num_chan_p; c++) outst_q[c] <= outst_d[c];
    end
  end

  assign link.out_v       = out_v_q;
  assign link.out_packet  = out_packet_q;
  assign credits_avail_o  = credits_q;
  assign invalid_access_o = invalid_q;

`ifdef NETWORK_TX_ARB_STATS_EN
  logic [31:0] stat_q [num_chan_p];
  logic [31:0] stat_d [num_chan_p];

  always_comb begin
    for (int unsigned c = 0; c < num_chan_p; c++) begin
      stat_d[c]             = stat_q[c] + 32'(grant_oh[c]);
      stat_sent_o[c*32 +: 32] = stat_q[c];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned c = 0; c < num_chan_p; c++) stat_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < num_chan_p; c++) stat_q[c] <= stat_d[c];
    end
  end
`else
  assign stat_sent_o = '0;
`endif

  a_credit_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i) !credit_overflow);
  a_resp_at_zero:    assert property (@(posedge clk_i) disable iff (!reset_n_i) !resp_at_zero);

  for (genvar c = 0; c < num_chan_p; c++) begin : g_hold
    a_pkt_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (link.req_v[c] && !link.req_yumi[c]) |=>
      (!link.req_v[c] || $stable(link.req_packet[c*packet_width_p +: packet_width_p])));
  end
endmodule

// File: tb/tb_network_tx_arb.sv
module tb_network_tx_arb;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         resp_v, mresp_v;
  logic [1:0]   resp_chan, mresp_chan;
  logic [3:0]   oz, moz, inv, minv;
  logic [5:0]   cred, mcred;
  logic [127:0] stat, mstat;
  int           n_chk = 0;
  int           n_bad = 0;
  logic [31:0]  pk [4];

  always #5 clk = ~clk;

  network_tx_arb_if #(.num_chan_p(4), .packet_width_p(32)) tif ();
  network_tx_arb_if #(.num_chan_p(4), .packet_width_p(32)) mif ();

  network_tx_arb #(.num_chan_p(4), .packet_width_p(32), .max_out_credits_p(32),
                   .max_outstanding_p(63)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .link(tif.slave),
    .resp_v_i(resp_v), .resp_chan_i(resp_chan),
    .outstanding_zero_o(oz), .credits_avail_o(cred),
    .invalid_access_o(inv), .stat_sent_o(stat));

  network_tx_arb #(.num_chan_p(4), .packet_width_p(32), .max_out_credits_p(32),
                   .max_outstanding_p(3)) dut_m3 (
    .clk_i(clk), .reset_n_i(rst_n), .link(mif.slave),
    .resp_v_i(mresp_v), .resp_chan_i(mresp_chan),
    .outstanding_zero_o(moz), .credits_avail_o(mcred),
    .invalid_access_o(minv), .stat_sent_o(mstat));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input int c, input logic [31:0] v);
    tif.req_packet[c*32 +: 32] = v;
  endtask

  task automatic set_mpkt(input int c, input logic [31:0] v);
    mif.req_packet[c*32 +: 32] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; resp_v = 1'b0; resp_chan = '0; mresp_v = 1'b0; mresp_chan = '0;
    tif.req_v = '0; tif.req_invalid = '0; tif.req_packet = '0; tif.out_credit = 1'b0;
    mif.req_v = '0; mif.req_invalid = '0; mif.req_packet = '0; mif.out_credit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_v", tif.out_v, 0);
    check("rst_out_pkt", tif.out_packet, 0);
    check("rst_cred", cred, 32);
    check("rst_oz", oz, 4'hF);
    check("rst_inv", inv, 0);
    check("rst_stat", stat[63:0], 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Channel 0 alone drains all 32 credits.
    tif.req_v = 4'b0001;
    for (int k = 0; k < 32; k++) begin
      set_pkt(0, 32'hA000_0000 + k);
      #1 check("t1_yumi", tif.req_yumi, 4'b0001);
      step();
      check("t1_v", tif.out_v, 1);
      check("t1_pkt", tif.out_packet, 32'hA000_0000 + k);
    end
    check("t1_cred0", cred, 0);
    set_pkt(0, 32'hA000_0020);
    #1 check("t1_stall_yumi", tif.req_yumi, 0);
    step();
    check("t1_stall_v", tif.out_v, 0);
    tif.out_credit = 1'b1;
    #1 check("t1_credcyc_yumi", tif.req_yumi, 0);
    step();
    tif.out_credit = 1'b0;
    check("t1_cred1", cred, 1);
    #1 check("t1_regrant_yumi", tif.req_yumi, 4'b0001);
    step();
    check("t1_regrant_v", tif.out_v, 1);
    check("t1_regrant_pkt", tif.out_packet, 32'hA000_0020);
    check("t1_cred_end", cred, 0);
    tif.req_v = '0;
    check("t1_oz", oz, 4'b1110);
`ifdef NETWORK_TX_ARB_STATS_EN
    check("t1_stat0", stat[31:0], 33);
`else
    check("t1_stat_tied", stat == '0, 1);
`endif

    // Invalid request on channel 2 with no credits: dropped immediately.
    tif.req_v = 4'b0100; tif.req_invalid = 4'b0100;
    #1 check("t3_yumi", tif.req_yumi, 4'b0100);
    step();
    check("t3_v", tif.out_v, 0);
    check("t3_inv", inv, 4'b0100);
    check("t3_cred", cred, 0);
    tif.req_v = '0; tif.req_invalid = '0;
    step();
    check("t3_inv_sticky", inv, 4'b0100);

    for (int k = 0; k < 32; k++) begin
      tif.out_credit = 1'b1;
      step();
    end
    tif.out_credit = 1'b0;
    check("refill_cred", cred, 32);

    // Channel 1 outstanding tracking.
    tif.req_v = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      set_pkt(1, 32'hB100_0000 + k);
      #1 check("t4_yumi", tif.req_yumi, 4'b0010);
      step();
      check("t4_pkt", tif.out_packet, 32'hB100_0000 + k);
    end
    tif.req_v = '0;
    check("t4_oz_busy", oz, 4'b1100);
    resp_chan = 2'd1;
    for (int k = 0; k < 3; k++) begin
      resp_v = 1'b1;
      step();
      check("t4_oz_resp", oz[1], (k == 2) ? 1 : 0);
    end
    resp_v = 1'b0;
    tif.req_v = 4'b0010;
    set_pkt(1, 32'hB100_0010);
    step();
    set_pkt(1, 32'hB100_0011);
    resp_v = 1'b1;
    #1 check("t4_both_yumi", tif.req_yumi, 4'b0010);
    step();
    resp_v = 1'b0; tif.req_v = '0;
    check("t4_both_pkt", tif.out_packet, 32'hB100_0011);
    check("t4_both_oz", oz[1], 0);
    resp_v = 1'b1;
    step();
    resp_v = 1'b0;
    check("t4_final_oz", oz[1], 1);
    check("t4_cred", cred, 27);

    // All four channels; pointer sits at 2 after the channel-1 grants.
    for (int c = 0; c < 4; c++) begin
      pk[c] = 32'hC000_0000 + (c << 16);
      set_pkt(c, pk[c]);
    end
    tif.req_v = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      int e;
      e = (2 + i) % 4;
      #1 check("t2_yumi", tif.req_yumi, 64'(1 << e));
      step();
      check("t2_v", tif.out_v, 1);
      check("t2_pkt", tif.out_packet, pk[e]);
      pk[e] = pk[e] + 1;
      set_pkt(e, pk[e]);
    end
    tif.req_v = '0;
    check("t2_cred", cred, 19);

    // Outstanding ceiling of 3 on the second instance.
    mif.req_v = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      set_mpkt(3, 32'hD300_0000 + k);
      #1 check("t5_fill_yumi", mif.req_yumi, 4'b1000);
      step();
      check("t5_fill_pkt", mif.out_packet, 32'hD300_0000 + k);
    end
    set_mpkt(3, 32'hD300_0003);
    check("t5_moz", moz, 4'b0111);
    mif.req_v = 4'b1001;
    mresp_chan = 2'd3;
    for (int j = 0; j < 3; j++) begin
      set_mpkt(0, 32'hD000_0000 + j);
      mresp_v = (j == 2);
      #1 check("t5_stall_yumi", mif.req_yumi, 4'b0001);
      step();
      check("t5_other_pkt", mif.out_packet, 32'hD000_0000 + j);
    end
    mresp_v = 1'b0;
    set_mpkt(0, 32'hD000_0003);
    #1 check("t5_resume_yumi", mif.req_yumi, 4'b1000);
    step();
    check("t5_resume_pkt", mif.out_packet, 32'hD300_0003);
    mif.req_v = '0;

    // Asynchronous reset in the middle of a burst.
    tif.req_v = 4'b1111;
    step();
    step();
    check("t6_pre_v", tif.out_v, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_v", tif.out_v, 0);
    check("t6_cred", cred, 32);
    check("t6_oz", oz, 4'hF);
    check("t6_moz", moz, 4'hF);
    check("t6_inv", inv, 0);
    check("t6_stat", stat[63:0], 0);
    tif.req_v = '0;
    @(negedge clk) rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
